instmem_loadable: RTL and testbench

- Parametrised successor to the fixed instruction ROM: a word-addressed instruction RAM with a byte-serial program loader and a registered fetch port.
- Sits between the PC/fetch stage and an external program source (UART/bench). The program is loaded after reset and then served to the CPU.
- Adds load/run modes, a valid/ready load handshake, a loaded-length limit and address-error reporting.

---
 rtl/instmem_pkg.sv | 19 +
 rtl/instmem_byte_packer.sv | 55 +++++
 rtl/instmem_loadable.sv | 135 +++++++++++++
 tb/tb_instmem_loadable.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instmem_pkg.sv
// Shared types and constants for the loadable instruction memory.
// Optional feature macro: INSTMEM_PARITY_EN (see instmem_loadable).
package instmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned BYTES_PER_WORD = DEFAULT_DATA_W / 8;
    localparam logic [DEFAULT_DATA_W-1:0] NOP = '0;

    function automatic int unsigned bytes_per_word(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/instmem_byte_packer.sv
// Assembles little-endian program bytes into words; flushes a partial word
// (upper bytes zero) when the load is finalised.
module instmem_byte_packer
    import instmem_pkg::*;
#(
    parameter int unsigned BYTES = BYTES_PER_WORD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               restart,
    input  logic               byte_en,
    input  logic [7:0]         byte_in,
    input  logic               flush,
    output logic               word_we,
    output logic [BYTES*8-1:0] word_data
);

    localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BYTES*8-1:0] asm_q, asm_d, merged;
    logic               last_byte, pending;

    always_comb begin
        merged = asm_q;
        if (byte_en) begin
            merged[32'(idx_q)*8 +: 8] = byte_in;
        end
        last_byte = byte_en && (32'(idx_q) == BYTES - 1);
        pending   = byte_en || (idx_q != '0);
        word_we   = last_byte || (flush && pending);
        word_data = merged;

        idx_d = idx_q;
        asm_d = asm_q;
        if (restart || word_we || flush) begin
            idx_d = '0;
            asm_d = '0;
        end else if (byte_en) begin
            idx_d = idx_q + IDX_W'(1);
            asm_d = merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            asm_q <= '0;
        end else begin
            idx_q <= idx_d;
            asm_q <= asm_d;
        end
    end

endmodule

// File: rtl/instmem_loadable.sv
// Word-addressed instruction RAM with a byte-serial loader and registered fetch port.
// Define INSTMEM_PARITY_EN to store an even-parity bit per word and add the ParErr output.
module instmem_loadable
    import instmem_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 5,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              Clk,
    input  logic              Clrn,
    input  logic              LdStart,
    input  logic              LdValid,
    input  logic [7:0]        LdByte,
    output logic              LdReady,
    input  logic              LdDone,
    input  logic              FetchReq,
    input  logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] Inst,
    output logic              InstValid,
    output logic              AddrErr,
    output logic              Busy,
    output logic [DEPTH_LOG2:0] WordCnt
`ifdef INSTMEM_PARITY_EN
    ,
    output logic              ParErr
`endif
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned BPW   = bytes_per_word(DATA_W);

    state_e              state_q;
    logic [DEPTH_LOG2:0] cnt_q;
    logic [DATA_W-1:0]   mem [DEPTH];
`ifdef INSTMEM_PARITY_EN
    logic                par_mem [DEPTH];
`endif

    logic                  byte_acc, flush, word_we;
    logic [DATA_W-1:0]     word_data;
    logic [DEPTH_LOG2-1:0] wr_idx, rd_idx;
    logic                  addr_bad;

    // The write pointer always equals the loaded word count, so one register serves both.
    assign Busy    = (state_q == LOAD);
    assign LdReady = Busy && !cnt_q[DEPTH_LOG2];
    assign WordCnt = cnt_q;

    assign byte_acc = LdValid && LdReady && !LdStart;
    assign flush    = Busy && LdDone && !LdStart;
    assign wr_idx   = cnt_q[DEPTH_LOG2-1:0];
    assign rd_idx   = Addr[DEPTH_LOG2+1:2];
    assign addr_bad = (Addr[1:0] != 2'b00) || ((Addr >> (DEPTH_LOG2 + 2)) != '0) ||
                      ({1'b0, rd_idx} >= cnt_q);

    instmem_byte_packer #(
        .BYTES (BPW)
    ) u_packer (
        .clk       (Clk),
        .rst_n     (Clrn),
        .restart   (LdStart),
        .byte_en   (byte_acc),
        .byte_in   (LdByte),
        .flush     (flush),
        .word_we   (word_we),
        .word_data (word_data)
    );

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (LdStart) begin
            state_q <= LOAD;
            cnt_q   <= '0;
        end else if (state_q == LOAD) begin
            if (word_we) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (LdDone) begin
                state_q <= RUN;
            end
        end
    end

    // Array is deliberately not reset; unloaded words are unreachable through WordCnt.
    always_ff @(posedge Clk) begin
        if (word_we) begin
            mem[wr_idx] <= word_data;
`ifdef INSTMEM_PARITY_EN
            par_mem[wr_idx] <= ^word_data;
`endif
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            Inst      <= DATA_W'(NOP);
            InstValid <= 1'b0;
            AddrErr   <= 1'b0;
`ifdef INSTMEM_PARITY_EN
            ParErr    <= 1'b0;
`endif
        end else begin
            Inst      <= DATA_W'(NOP);
            InstValid <= 1'b0;
            AddrErr   <= 1'b0;
`ifdef INSTMEM_PARITY_EN
            ParErr    <= 1'b0;
`endif
            if (FetchReq) begin
                unique case (state_q)
                    IDLE: begin
                        InstValid <= 1'b1;
                        AddrErr   <= 1'b1;
                    end
                    RUN: begin
                        InstValid <= 1'b1;
                        if (addr_bad) begin
                            AddrErr <= 1'b1;
                        end else begin
                            Inst <= mem[rd_idx];
`ifdef INSTMEM_PARITY_EN
                            ParErr <= (^mem[rd_idx]) != par_mem[rd_idx];
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instmem_loadable.sv
// Self-checking bench for instmem_loadable: directed plan plus randomized loads/fetches
// against a byte-queue reference model. Honours INSTMEM_PARITY_EN when defined.
module tb_instmem_loadable;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_start = 1'b0, ld_valid = 1'b0, ld_done = 1'b0, fetch_req = 1'b0;
    logic [7:0]  ld_byte = '0;
    logic [31:0] addr = '0;
    logic        ld_ready, inst_valid, addr_err, busy;
    logic [31:0] inst;
    logic [5:0]  word_cnt;
`ifdef INSTMEM_PARITY_EN
    logic        par_err;
`endif

    instmem_loadable #(
        .DATA_W     (32),
        .DEPTH_LOG2 (5),
        .ADDR_W     (32)
    ) dut (
        .Clk       (clk),
        .Clrn      (rst_n),
        .LdStart   (ld_start),
        .LdValid   (ld_valid),
        .LdByte    (ld_byte),
        .LdReady   (ld_ready),
        .LdDone    (ld_done),
        .FetchReq  (fetch_req),
        .Addr      (addr),
        .Inst      (inst),
        .InstValid (inst_valid),
        .AddrErr   (addr_err),
        .Busy      (busy),
        .WordCnt   (word_cnt)
`ifdef INSTMEM_PARITY_EN
        ,
        .ParErr    (par_err)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 idle, 1 load, 2 run.
    int unsigned  m_state = 0;
    int unsigned  m_cnt = 0;
    logic [7:0]   m_bytes[$];
    logic [31:0]  m_mem [32];
    bit           m_corrupt [32];
    logic         e_valid = 1'b0, e_err = 1'b0, e_par = 1'b0;
    logic [31:0]  e_inst = '0;

    task automatic model_reset();
        m_state = 0;
        m_cnt = 0;
        m_bytes.delete();
        e_valid = 1'b0;
        e_err = 1'b0;
        e_inst = '0;
        e_par = 1'b0;
    endtask

    task automatic model_step();
        int unsigned widx;
        logic [31:0] word;
        e_valid = 1'b0;
        e_err = 1'b0;
        e_inst = '0;
        e_par = 1'b0;
        if (fetch_req) begin
            widx = addr >> 2;
            if (m_state == 0) begin
                e_valid = 1'b1;
                e_err = 1'b1;
            end else if (m_state == 2) begin
                e_valid = 1'b1;
                if ((addr % 4) != 0 || widx >= m_cnt) begin
                    e_err = 1'b1;
                end else begin
                    e_inst = m_mem[widx];
                    e_par = m_corrupt[widx];
                end
            end
        end
        if (ld_start) begin
            m_state = 1;
            m_cnt = 0;
            m_bytes.delete();
        end else if (m_state == 1) begin
            if (ld_valid && m_cnt < 32) m_bytes.push_back(ld_byte);
            if (m_bytes.size() == 4 || (ld_done && m_bytes.size() > 0)) begin
                word = '0;
                for (int i = 0; i < m_bytes.size(); i++) word |= 32'(m_bytes[i]) << (8 * i);
                m_mem[m_cnt] = word;
                m_corrupt[m_cnt] = 1'b0;
                m_cnt++;
                m_bytes.delete();
            end
            if (ld_done) m_state = 2;
        end
    endtask

    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("inst_valid", 64'(inst_valid), 64'(e_valid));
            check("addr_err", 64'(addr_err), 64'(e_err));
            check("inst", 64'(inst), 64'(e_inst));
            check("ld_ready", 64'(ld_ready), 64'(m_state == 1 && m_cnt < 32));
            check("busy", 64'(busy), 64'(m_state == 1));
            check("word_cnt", 64'(word_cnt), 64'(m_cnt));
`ifdef INSTMEM_PARITY_EN
            check("par_err", 64'(par_err), 64'(e_par));
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        ld_valid = 1'b1;
        ld_byte = b;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic pulse_start();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic pulse_done();
        ld_done = 1'b1;
        tick();
        ld_done = 1'b0;
    endtask

    task automatic fetch1(input logic [31:0] a);
        fetch_req = 1'b1;
        addr = a;
        tick();
        fetch_req = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom % 4)
            0: a = ($urandom % 36) * 4;
            1: a = ($urandom % 36) * 4 + 1 + ($urandom % 3);
            2: a = (32'h1 << (7 + $urandom % 25)) | (($urandom % 32) * 4);
            default: a = $urandom;
        endcase
        return a;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_corrupt[i] = 1'b0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        tick();
        #2 rst_n = 1'b1;
        check("rst_inst_valid", 64'(inst_valid), 64'h0);
        check("rst_word_cnt", 64'(word_cnt), 64'h0);
        tick();

        // IDLE fetch returns an address error.
        fetch1(32'h0);
        check("idle_valid", 64'(inst_valid), 64'h1);
        check("idle_err", 64'(addr_err), 64'h1);
        check("idle_inst", 64'(inst), 64'h0);

        // Two full words, fetched back to back.
        pulse_start();
        foreach (m_bytes[i]) ; // no-op keeps queue type usage explicit
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        pulse_done();
        fetch_req = 1'b1;
        addr = 32'h0;
        tick();
        check("b2b_word0", 64'(inst), 64'h12345678);
        addr = 32'h4;
        tick();
        check("b2b_word1", 64'(inst), 64'hDEADBEEF);
        check("b2b_cnt", 64'(word_cnt), 64'd2);
        fetch_req = 1'b0;
        tick();

        // Partial word flushed on LdDone.
        pulse_start();
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        pulse_done();
        fetch1(32'h0);
        check("partial_inst", 64'(inst), 64'h00CCBBAA);
        check("partial_cnt", 64'(word_cnt), 64'd1);
        fetch1(32'h4);
        check("beyond_cnt_err", 64'(addr_err), 64'h1);
        check("beyond_cnt_inst", 64'(inst), 64'h0);

        // Fill all 32 words, then an extra byte that must be ignored.
        pulse_start();
        for (int k = 0; k < 128; k++) send_byte(8'(k));
        check("full_ready", 64'(ld_ready), 64'h0);
        check("full_cnt", 64'(word_cnt), 64'd32);
        send_byte(8'hFF);
        check("full_cnt_after", 64'(word_cnt), 64'd32);
        pulse_done();
        fetch1(32'h7C);
        check("word31", 64'(inst), 64'h7F7E7D7C);
        check("word31_err", 64'(addr_err), 64'h0);
        fetch1(32'h80);
        check("oor_err", 64'(addr_err), 64'h1);
        fetch1(32'h2);
        check("misalign_err", 64'(addr_err), 64'h1);
        check("misalign_inst", 64'(inst), 64'h0);

        // Reset in the middle of a load.
        pulse_start();
        send_byte(8'h01); send_byte(8'h02);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'h0);
        check("midrst_ready", 64'(ld_ready), 64'h0);
        check("midrst_cnt", 64'(word_cnt), 64'h0);
        check("midrst_valid", 64'(inst_valid), 64'h0);
        check("midrst_err", 64'(addr_err), 64'h0);
        check("midrst_inst", 64'(inst), 64'h0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        fetch1(32'h0);
        check("postrst_idle_err", 64'(addr_err), 64'h1);

        // Restart from RUN; fetches during LOAD and with LdDone are ignored.
        pulse_start();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        pulse_done();
        fetch1(32'h0);
        check("run_word", 64'(inst), 64'h44332211);
        pulse_start();
        check("restart_cnt", 64'(word_cnt), 64'h0);
        fetch1(32'h0);
        check("load_busy", 64'(busy), 64'h1);
        check("load_fetch_ignored", 64'(inst_valid), 64'h0);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        ld_done = 1'b1;
        fetch_req = 1'b1;
        addr = 32'h0;
        tick();
        ld_done = 1'b0;
        fetch_req = 1'b0;
        check("done_fetch_ignored", 64'(inst_valid), 64'h0);
        fetch1(32'h0);
        check("reload_word", 64'(inst), 64'h04030201);
        check("reload_cnt", 64'(word_cnt), 64'd1);

        // Randomized loads, restarts and fetches.
        for (int r = 0; r < 6; r++) begin
            int unsigned n;
            pulse_start();
            n = $urandom % 150;
            for (int c = 0; c < n; c++) begin
                ld_valid = ($urandom % 4) != 0;
                ld_byte = 8'($urandom);
                fetch_req = ($urandom % 8) == 0;
                addr = rand_addr();
                ld_start = ($urandom % 60) == 0;
                tick();
                ld_start = 1'b0;
            end
            ld_valid = ($urandom % 2) != 0;
            ld_byte = 8'($urandom);
            ld_done = 1'b1;
            ld_start = ($urandom % 5) == 0;
            tick();
            ld_valid = 1'b0;
            ld_start = 1'b0;
            ld_done = 1'b0;
            pulse_done();
            for (int c = 0; c < 50; c++) begin
                fetch_req = ($urandom % 4) != 0;
                addr = rand_addr();
                tick();
            end
            fetch_req = 1'b0;
        end

`ifdef INSTMEM_PARITY_EN
        pulse_start();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        pulse_done();
        dut.mem[0] = 32'h0;
        m_mem[0] = 32'h0;
        m_corrupt[0] = 1'b1;
        fetch1(32'h0);
        check("parity_err_lit", 64'(par_err), 64'h1);
        check("parity_inst_lit", 64'(inst), 64'h0);
        fetch1(32'h2);
        check("parity_masked_by_addr_err", 64'(par_err), 64'h0);
`endif

        tick();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
